blend_stage: RTL and testbench

- Framebuffer blend stage of the fragment pipeline.
- Takes a source fragment colour plus the destination colour read from the colour buffer, and decodes per-fragment blend factors into the four operand vectors of the ColorMixer child instance, which computes (A*B)+(C*D) with saturation.
- Carries the fragment address alongside as sideband.
- Decouples the fixed-latency mixer from a back-pressuring framebuffer writer with a credit-controlled output FIFO.

---
 rtl/blend_stage.sv | 204 ++++++++++++++++++++
 tb/tb_blend_stage.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/blend_stage.sv
// Framebuffer blend stage: factor decode, 2-stage ColorMixer, credit-guarded output FIFO.
// Optional macro BLEND_CONSTANT_COLOR_EN adds conf_constColor and factor codes 11-14.

// Per channel: result = sat((a*b + a) >> W + (c*d + c) >> W); the "+a" term makes an all-ones factor an exact identity.
module ColorMixer #(
    parameter int unsigned W = 8
) (
    input  logic           clk,
    input  logic [4*W-1:0] a,
    input  logic [4*W-1:0] b,
    input  logic [4*W-1:0] c,
    input  logic [4*W-1:0] d,
    output logic [4*W-1:0] result
);
    logic [W-1:0] ab_q [4];
    logic [W-1:0] cd_q [4];

    function automatic logic [W-1:0] mul(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [2*W-1:0] xe;
        logic [2*W-1:0] ye;
        xe = {{W{1'b0}}, x};
        ye = {{W{1'b0}}, y};
        return W'((xe * ye + xe) >> W);
    endfunction

    function automatic logic [W-1:0] sat_add(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W:0] s;
        s = {1'b0, x} + {1'b0, y};
        return s[W] ? '1 : s[W-1:0];
    endfunction

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < 4; i++) begin
            ab_q[i] <= mul(a[i*W +: W], b[i*W +: W]);
            cd_q[i] <= mul(c[i*W +: W], d[i*W +: W]);
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < 4; i++) begin
            result[i*W +: W] <= sat_add(ab_q[i], cd_q[i]);
        end
    end
endmodule

module blend_stage #(
    parameter int unsigned SUB_PIXEL_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH      = 16,
    parameter int unsigned FIFO_DEPTH      = 8
) (
    input  logic                         aclk,
    input  logic                         resetn,
    input  logic                         s_valid,
    output logic                         s_ready,
    input  logic [4*SUB_PIXEL_WIDTH-1:0] s_src,
    input  logic [4*SUB_PIXEL_WIDTH-1:0] s_dst,
    input  logic [ADDR_WIDTH-1:0]        s_addr,
    input  logic                         conf_enable,
    input  logic [3:0]                   conf_srcFactor,
    input  logic [3:0]                   conf_dstFactor,
`ifdef BLEND_CONSTANT_COLOR_EN
    input  logic [4*SUB_PIXEL_WIDTH-1:0] conf_constColor,
`endif
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic [4*SUB_PIXEL_WIDTH-1:0] m_color,
    output logic [ADDR_WIDTH-1:0]        m_addr
);
    localparam int unsigned W    = SUB_PIXEL_WIDTH;
    localparam int unsigned PW   = 4 * W;
    localparam int unsigned PTRW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW   = PTRW + 1;

    function automatic logic [PW-1:0] factor(
        input logic [3:0]    code,
        input logic [PW-1:0] src,
`ifdef BLEND_CONSTANT_COLOR_EN
        input logic [PW-1:0] cst,
`endif
        input logic [PW-1:0] dst
    );
        logic [W-1:0] sa;
        logic [W-1:0] nda;
        logic [W-1:0] sat;
        sa  = src[W-1:0];
        nda = ~dst[W-1:0];
        sat = (sa < nda) ? sa : nda;
        case (code)
            4'd1:    return '1;
            4'd2:    return dst;
            4'd3:    return ~dst;
            4'd4:    return {4{sa}};
            4'd5:    return ~{4{sa}};
            4'd6:    return {4{dst[W-1:0]}};
            4'd7:    return {4{nda}};
            4'd8:    return {{3{sat}}, {W{1'b1}}};
            4'd9:    return src;
            4'd10:   return ~src;
`ifdef BLEND_CONSTANT_COLOR_EN
            4'd11:   return cst;
            4'd12:   return ~cst;
            4'd13:   return {4{cst[W-1:0]}};
            4'd14:   return ~{4{cst[W-1:0]}};
`endif
            default: return '0;
        endcase
    endfunction

    logic [PW-1:0]         src_factor, dst_factor;
    logic                  accept;
    logic                  v_s1, v_s2, v_s3;
    logic [ADDR_WIDTH-1:0] addr_s1, addr_s2, addr_s3;
    logic [PW-1:0]         op_a, op_b, op_c, op_d, mix_color;
    logic [CW:0]           used;

    logic [PW+ADDR_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTRW-1:0]          wr_ptr, rd_ptr;
    logic [CW-1:0]            fifo_count;
    logic                     push, pop, direct, mem_we;

    always_comb begin
`ifdef BLEND_CONSTANT_COLOR_EN
        src_factor = factor(conf_srcFactor, s_src, conf_constColor, s_dst);
        dst_factor = factor(conf_dstFactor, s_src, conf_constColor, s_dst);
`else
        src_factor = factor(conf_srcFactor, s_src, s_dst);
        dst_factor = factor(conf_dstFactor, s_src, s_dst);
`endif
    end

    // Credits: every fragment in the pipe already owns a FIFO slot, so the pipe never needs to stall.
    assign used    = (CW+1)'(fifo_count) + (CW+1)'(v_s1) + (CW+1)'(v_s2) + (CW+1)'(v_s3);
    assign s_ready = resetn && (used < (CW+1)'(FIFO_DEPTH));
    assign accept  = s_valid && s_ready;

    always_ff @(posedge aclk or negedge resetn) begin
        if (!resetn) begin
            v_s1    <= 1'b0;
            v_s2    <= 1'b0;
            v_s3    <= 1'b0;
            addr_s1 <= '0;
            addr_s2 <= '0;
            addr_s3 <= '0;
            op_a    <= '0;
            op_b    <= '0;
            op_c    <= '0;
            op_d    <= '0;
        end else begin
            v_s1    <= accept;
            v_s2    <= v_s1;
            v_s3    <= v_s2;
            addr_s2 <= addr_s1;
            addr_s3 <= addr_s2;
            if (accept) begin
                addr_s1 <= s_addr;
                op_a    <= s_src;
                op_b    <= conf_enable ? src_factor : '1;
                op_c    <= conf_enable ? s_dst : '0;
                op_d    <= conf_enable ? dst_factor : '0;
            end
        end
    end

    ColorMixer #(.W(W)) u_mixer (
        .clk    (aclk),
        .a      (op_a),
        .b      (op_b),
        .c      (op_c),
        .d      (op_d),
        .result (mix_color)
    );

    // The output register holds the head entry; mem holds the entries behind it.
    assign m_valid = (fifo_count != '0);
    assign push    = v_s3;
    assign pop     = m_valid && m_ready;
    assign direct  = (fifo_count == '0) || ((fifo_count == CW'(1)) && pop);
    assign mem_we  = push && !direct;

    always_ff @(posedge aclk) begin
        if (mem_we) mem[wr_ptr] <= {mix_color, addr_s3};
    end

    always_ff @(posedge aclk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            m_color    <= '0;
            m_addr     <= '0;
        end else begin
            if (push && direct) begin
                m_color <= mix_color;
                m_addr  <= addr_s3;
            end else if (pop && (fifo_count > CW'(1))) begin
                {m_color, m_addr} <= mem[rd_ptr];
                rd_ptr            <= rd_ptr + 1'b1;
            end
            if (mem_we) wr_ptr <= wr_ptr + 1'b1;
            if (push && !pop)      fifo_count <= fifo_count + 1'b1;
            else if (pop && !push) fifo_count <= fifo_count - 1'b1;
        end
    end
endmodule

// File: tb/tb_blend_stage.sv
// Scoreboard bench for blend_stage: driver queues hand-computed results, monitor pops on each handshake.
module tb_blend_stage;
    logic        aclk = 1'b0;
    logic        resetn = 1'b0;
    logic        s_valid, s_ready, conf_enable, m_valid, m_ready;
    logic [31:0] s_src, s_dst, m_color;
    logic [15:0] s_addr, m_addr;
    logic [3:0]  conf_srcFactor, conf_dstFactor;
`ifdef BLEND_CONSTANT_COLOR_EN
    logic [31:0] conf_constColor = '0;
`endif

    int checks = 0;
    int failures = 0;
    int out_idx = 0;
    logic [31:0] q_color[$];
    logic [15:0] q_addr[$];

    always #5 aclk = ~aclk;

    blend_stage #(.SUB_PIXEL_WIDTH(8), .ADDR_WIDTH(16), .FIFO_DEPTH(8)) dut (
        .aclk           (aclk),
        .resetn         (resetn),
        .s_valid        (s_valid),
        .s_ready        (s_ready),
        .s_src          (s_src),
        .s_dst          (s_dst),
        .s_addr         (s_addr),
        .conf_enable    (conf_enable),
        .conf_srcFactor (conf_srcFactor),
        .conf_dstFactor (conf_dstFactor),
`ifdef BLEND_CONSTANT_COLOR_EN
        .conf_constColor(conf_constColor),
`endif
        .m_valid        (m_valid),
        .m_ready        (m_ready),
        .m_color        (m_color),
        .m_addr         (m_addr)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge aclk) begin
        if (resetn && m_valid && m_ready) begin
            if (q_color.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_output: got color %h addr %h expected no output", m_color, m_addr);
            end else begin
                logic [31:0] ec;
                logic [15:0] ea;
                ec = q_color.pop_front();
                ea = q_addr.pop_front();
                check($sformatf("color[%0d]", out_idx), m_color, ec);
                check($sformatf("addr[%0d]", out_idx), {16'h0, m_addr}, {16'h0, ea});
                out_idx++;
            end
        end
    end

    function automatic logic [31:0] bp_color(input int i);
        return 32'hC0DE0000 | 32'(i);
    endfunction

    // Called just after a posedge; returns just after the accepting posedge with s_valid still high.
    task automatic send(input logic [31:0] src, input logic [31:0] dst, input logic [15:0] addr,
                        input logic en, input logic [3:0] sf, input logic [3:0] df, input logic [31:0] exp);
        int n;
        s_valid = 1'b1; s_src = src; s_dst = dst; s_addr = addr;
        conf_enable = en; conf_srcFactor = sf; conf_dstFactor = df;
        n = 0;
        @(negedge aclk);
        while (!s_ready && n < 200) begin
            n++;
            @(negedge aclk);
        end
        if (!s_ready) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: got s_ready 0 expected 1 for addr %h", addr);
        end else begin
            q_color.push_back(exp);
            q_addr.push_back(addr);
        end
        @(posedge aclk); #1;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (q_color.size() != 0 && n < 300) begin
            n++;
            @(negedge aclk);
        end
        @(negedge aclk);
        check(name, 32'(q_color.size()), 32'd0);
    endtask

    task automatic stream(input int first, input int last, input int max_iter, output int next, output int iters);
        next = first;
        iters = 0;
        s_valid = 1'b1;
        conf_enable = 1'b0; conf_srcFactor = 4'd0; conf_dstFactor = 4'd0;
        while (next < last && iters < max_iter) begin
            s_src = bp_color(next); s_dst = 32'hFFFFFFFF; s_addr = 16'h0300 + 16'(next);
            @(negedge aclk);
            if (s_ready) begin
                q_color.push_back(bp_color(next));
                q_addr.push_back(16'h0300 + 16'(next));
                next++;
            end
            iters++;
            @(posedge aclk); #1;
        end
        s_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx, iters;
        s_valid = 1'b0; m_ready = 1'b0; conf_enable = 1'b0;
        conf_srcFactor = 4'd0; conf_dstFactor = 4'd0;
        s_src = '0; s_dst = '0; s_addr = '0;

        #12;
        check("rst_s_ready", {31'h0, s_ready}, 32'd0);
        check("rst_m_valid", {31'h0, m_valid}, 32'd0);
        check("rst_m_color", m_color, 32'd0);
        check("rst_m_addr", {16'h0, m_addr}, 32'd0);
        @(posedge aclk); #1 resetn = 1'b1;
        @(negedge aclk);
        check("rel_s_ready", {31'h0, s_ready}, 32'd1);
        @(posedge aclk); #1;

        // Bypass with a non-zero dst factor that must be ignored; latency is 3 edges.
        m_ready = 1'b1;
        send(32'h11223344, 32'hFFFFFFFF, 16'h0101, 1'b0, 4'd0, 4'd1, 32'h11223344);
        s_valid = 1'b0;
        @(posedge aclk);
        @(posedge aclk);
        @(negedge aclk);
        check("latency_k2_m_valid", {31'h0, m_valid}, 32'd0);
        @(negedge aclk);
        check("latency_k3_m_valid", {31'h0, m_valid}, 32'd1);
        wait_drain("drain_bypass");
        @(posedge aclk); #1;

        // Back-to-back fragments; config changes every cycle.
        send(32'h80808080, 32'h90909090, 16'h0201, 1'b1, 4'd1,  4'd1,  32'hFFFFFFFF);
        send(32'h80808080, 32'h90909090, 16'h0202, 1'b1, 4'd0,  4'd0,  32'h00000000);
        send(32'h80808080, 32'h90909090, 16'h0203, 1'b1, 4'd0,  4'd1,  32'h90909090);
        send(32'hFF000040, 32'h00FF80C0, 16'h0204, 1'b1, 4'd4,  4'd5,  32'h40BF60A0);
        send(32'h10203080, 32'h112233C0, 16'h0205, 1'b1, 4'd8,  4'd0,  32'h04080C80);
        send(32'hFF804020, 32'h80FF40FF, 16'h0206, 1'b1, 4'd2,  4'd0,  32'h80801020);
        send(32'h12345678, 32'h9ABCDEF0, 16'h0207, 1'b1, 4'd11, 4'd1,  32'h9ABCDEF0);
        send(32'hFFFFFFFF, 32'h40404040, 16'h0208, 1'b1, 4'd3,  4'd6,  32'hCFCFCFCF);
        send(32'hFF00FF00, 32'h11223344, 16'h0209, 1'b1, 4'd9,  4'd10, 32'hFF22FF44);
        send(32'h80808040, 32'h204060C0, 16'h020A, 1'b1, 4'd7,  4'd5,  32'h385068A0);
        s_valid = 1'b0;
        wait_drain("drain_vectors");
        @(posedge aclk); #1;

        // Back-pressure: exactly FIFO_DEPTH accepts, head held stable, then ordered drain.
        m_ready = 1'b0;
        stream(0, 20, 30, idx, iters);
        check("bp_accepts", 32'(idx), 32'd8);
        @(negedge aclk);
        check("bp_s_ready_low", {31'h0, s_ready}, 32'd0);
        check("bp_head_hold", m_color, bp_color(0));
        @(posedge aclk); #1;
        m_ready = 1'b1;
        stream(idx, 20, 200, idx, iters);
        check("bp_all_sent", 32'(idx), 32'd20);
        wait_drain("drain_bp");
        @(posedge aclk); #1;

        // Full throughput with m_ready held high.
        stream(100, 116, 100, idx, iters);
        check("throughput_cycles", 32'(iters), 32'd16);
        wait_drain("drain_tp");
        @(posedge aclk); #1;

        // Reset with 3 in flight and 2 in the FIFO.
        m_ready = 1'b0;
        stream(200, 205, 20, idx, iters);
        check("pre_reset_m_valid", {31'h0, m_valid}, 32'd1);
        resetn = 1'b0;
        #1;
        check("mid_rst_m_valid", {31'h0, m_valid}, 32'd0);
        check("mid_rst_m_color", m_color, 32'd0);
        check("mid_rst_s_ready", {31'h0, s_ready}, 32'd0);
        q_color.delete();
        q_addr.delete();
        @(posedge aclk); #1 resetn = 1'b1;
        @(negedge aclk);
        check("post_rst_s_ready", {31'h0, s_ready}, 32'd1);
        m_ready = 1'b1;
        repeat (20) @(negedge aclk);
        check("no_stale_m_valid", {31'h0, m_valid}, 32'd0);
        @(posedge aclk); #1;
        send(32'hA1B2C3D4, 32'h00000000, 16'h0777, 1'b0, 4'd0, 4'd0, 32'hA1B2C3D4);
        s_valid = 1'b0;
        wait_drain("drain_post_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
